camera_capture_winmod: RTL

Parametrised successor to the fixed single-window CMOS capture path. Runs entirely in the CLOCK domain. Oversamples the OV7670 PCLK/HREF/VSYNC/DQ bus, assembles RGB565 pixels, crops to a programmable window and packs PIX_PER_WORD pixels per output word. Words are delivered through an internal FWFT FIFO with a valid/ready handshake, frame/line tags and overflow detection. It sits between the sensor-config controller (which raises iEn once configured) and the frame-save buffer.

---
 rtl/camera_pkg.sv | 19 +
 rtl/camera_fifomod.sv | 70 +++++++
 rtl/camera_capture_winmod.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/camera_pkg.sv
// Shared constants, FSM encoding and entry-width helper for the capture path.
package camera_pkg;

  localparam int PIX_W       = 16;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    ACTIVE  = 2'd2,
    DROP    = 2'd3
  } cap_state_e;

  // FIFO entry = {sof, eol, packed pixels}
  function automatic int entry_width(input int pix_per_word);
    return PIX_W * pix_per_word + 2;
  endfunction

endpackage

// File: rtl/camera_fifomod.sv
// Synchronous first-word-fall-through FIFO with registered full/empty flags.
module camera_fifomod #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 16
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             empty_q, full_q;
  logic             do_push_s, do_pop_s;

  // A pop frees a slot in the same cycle, so push-while-full is legal when popping
  assign do_pop_s  = pop_i && !empty_q;
  assign do_push_s = push_i && (!full_q || do_pop_s);

  // Next occupancy from push/pop combination
  always_comb begin
    cnt_d = cnt_q;
    if (do_push_s && !do_pop_s) begin
      cnt_d = cnt_q + 1'b1;
    end else if (do_pop_s && !do_push_s) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Storage, pointers and occupancy flags
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      if (do_push_s) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop_s) begin
        rptr_q <= rptr_q + 1'b1;
      end
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == '0);
      full_q  <= (cnt_d == FULL_CNT);
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/camera_capture_winmod.sv
// OV7670 capture: oversampled bus, RGB565 assembly, window crop, packing, FWFT output.
module camera_capture_winmod
  import camera_pkg::*;
#(
  parameter int PIX_PER_WORD = 2,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int X0           = 0,
  parameter int Y0           = 0,
  parameter int WIN_W        = 640,
  parameter int WIN_H        = 480,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          CLOCK,
  input  logic                          RESET,
  input  logic                          CMOS_PCLK,
  input  logic                          CMOS_HREF,
  input  logic                          CMOS_VSYNC,
  input  logic [7:0]                    CMOS_DQ,
  input  logic                          iEn,
  input  logic                          iReady,
  output logic                          oEn,
  output logic [PIX_W*PIX_PER_WORD-1:0] oData,
  output logic                          oSof,
  output logic                          oEol,
  output logic                          oOverflow,
  output logic [7:0]                    oFrameCnt
);

  localparam int WW   = PIX_W * PIX_PER_WORD;
  localparam int EW   = entry_width(PIX_PER_WORD);
  localparam int LAST = SYNC_STAGES - 1;
  localparam int XW   = $clog2(H_ACTIVE + 1);
  localparam int YW   = $clog2(V_ACTIVE + 1);
  localparam logic [XW-1:0] X_LO   = XW'(X0);
  localparam logic [XW-1:0] X_SPAN = XW'(WIN_W);
  localparam logic [XW-1:0] X_LAST = XW'(X0 + WIN_W - 1);
  localparam logic [XW-1:0] X_MAX  = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LO   = YW'(Y0);
  localparam logic [YW-1:0] Y_SPAN = YW'(WIN_H);
  localparam logic [YW-1:0] Y_MAX  = YW'(V_ACTIVE - 1);
  localparam logic [2:0]    PIX_LAST = 3'(PIX_PER_WORD - 1);

  if ((PIX_PER_WORD != 1 && PIX_PER_WORD != 2 && PIX_PER_WORD != 4) ||
      (WIN_W % PIX_PER_WORD) != 0 || WIN_W < 1 || WIN_H < 1 || X0 < 0 || Y0 < 0 ||
      (X0 + WIN_W) > H_ACTIVE || (Y0 + WIN_H) > V_ACTIVE ||
      FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_err
    $error("camera_capture_winmod: illegal parameter set");
  end

  logic [SYNC_STAGES-1:0]      pclk_sync_q, href_sync_q, vs_sync_q;
  logic [SYNC_STAGES-1:0][7:0] dq_pipe_q;
  logic                        pclk_prev_q, href_prev_q, vs_prev_q;
  cap_state_e                  state_q;
  logic [7:0]                  frame_cnt_q;
  logic                        ovf_q, sof_pend_q;
  logic [XW-1:0]               x_q;
  logic [YW-1:0]               y_q;
  logic                        phase_q;
  logic [7:0]                  msb_q;
  logic [WW-1:0]               word_q;
  logic [2:0]                  pix_cnt_q;

  logic sample_s, byte_s, pix_done_s, href_fall_s, vs_rise_s, vs_fall_s;
  logic in_win_s, capture_s, word_full_s, push_req_s, pop_s, overflow_s;
  logic frame_start_s, eol_s, fifo_full_s, fifo_empty_s;
  logic [PIX_W-1:0] pix_s;
  logic [WW-1:0]    word_next_s;
  logic [EW-1:0]    fifo_rdata_s;

  // Bring the sensor bus into the CLOCK domain; DQ is delayed to stay aligned with PCLK
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      pclk_sync_q <= '0;
      href_sync_q <= '0;
      vs_sync_q   <= '0;
      dq_pipe_q   <= '0;
      pclk_prev_q <= 1'b0;
      href_prev_q <= 1'b0;
      vs_prev_q   <= 1'b0;
    end else begin
      pclk_sync_q <= {pclk_sync_q[SYNC_STAGES-2:0], CMOS_PCLK};
      href_sync_q <= {href_sync_q[SYNC_STAGES-2:0], CMOS_HREF};
      vs_sync_q   <= {vs_sync_q[SYNC_STAGES-2:0], CMOS_VSYNC};
      dq_pipe_q   <= {dq_pipe_q[SYNC_STAGES-2:0], CMOS_DQ};
      pclk_prev_q <= pclk_sync_q[LAST];
      href_prev_q <= href_sync_q[LAST];
      vs_prev_q   <= vs_sync_q[LAST];
    end
  end

  assign sample_s    = pclk_sync_q[LAST] && !pclk_prev_q;
  assign href_fall_s = href_prev_q && !href_sync_q[LAST];
  assign vs_rise_s   = vs_sync_q[LAST] && !vs_prev_q;
  assign vs_fall_s   = vs_prev_q && !vs_sync_q[LAST];
  assign byte_s      = sample_s && href_sync_q[LAST];
  assign pix_done_s  = byte_s && phase_q;
  assign pix_s       = {msb_q, dq_pipe_q[LAST]};

  // Subtract-and-compare wraps for positions below the window origin
  assign in_win_s    = ((x_q - X_LO) < X_SPAN) && ((y_q - Y_LO) < Y_SPAN);
  assign capture_s   = pix_done_s && in_win_s && (state_q == ACTIVE);
  assign word_full_s = (pix_cnt_q == PIX_LAST);
  assign push_req_s  = capture_s && word_full_s;
  assign word_next_s = WW'({word_q, pix_s});
  assign eol_s       = (x_q == X_LAST);
  assign pop_s       = iReady && !fifo_empty_s;
  assign overflow_s  = push_req_s && fifo_full_s && !pop_s;
  assign frame_start_s = (state_q == WAIT_VS) && vs_fall_s;

  // Capture FSM with frame counter, sticky overflow and start-of-frame tag
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      frame_cnt_q <= 8'd0;
      ovf_q       <= 1'b0;
      sof_pend_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (iEn) state_q <= WAIT_VS;
        end
        WAIT_VS: begin
          if (vs_fall_s) begin
            state_q    <= ACTIVE;
            ovf_q      <= 1'b0;
            sof_pend_q <= 1'b1;
          end
        end
        ACTIVE: begin
          if (vs_rise_s) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
            state_q     <= iEn ? WAIT_VS : IDLE;
          end else if (overflow_s) begin
            ovf_q   <= 1'b1;
            state_q <= DROP;
          end else if (push_req_s) begin
            sof_pend_q <= 1'b0;
          end
        end
        DROP: begin
          if (vs_rise_s) state_q <= iEn ? WAIT_VS : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Byte phase, line/column position and pixel packing
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      x_q       <= '0;
      y_q       <= '0;
      phase_q   <= 1'b0;
      msb_q     <= 8'd0;
      word_q    <= '0;
      pix_cnt_q <= 3'd0;
    end else if (frame_start_s) begin
      x_q       <= '0;
      y_q       <= '0;
      phase_q   <= 1'b0;
      pix_cnt_q <= 3'd0;
    end else if (href_fall_s) begin
      x_q       <= '0;
      phase_q   <= 1'b0;
      pix_cnt_q <= 3'd0;
      if (y_q != Y_MAX) y_q <= y_q + 1'b1;
    end else if (byte_s) begin
      phase_q <= !phase_q;
      if (!phase_q) begin
        msb_q <= dq_pipe_q[LAST];
      end else begin
        if (x_q != X_MAX) x_q <= x_q + 1'b1;
        if (capture_s) begin
          word_q    <= word_next_s;
          pix_cnt_q <= word_full_s ? 3'd0 : pix_cnt_q + 3'd1;
        end
      end
    end
  end

  camera_fifomod #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .push_i  (push_req_s),
    .wdata_i ({sof_pend_q, eol_s, word_next_s}),
    .pop_i   (pop_s),
    .rdata_o (fifo_rdata_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign oEn                 = !fifo_empty_s;
  assign {oSof, oEol, oData} = fifo_rdata_s;
  assign oOverflow           = ovf_q;
  assign oFrameCnt           = frame_cnt_q;

endmodule
